// File: rtl/sdc_mem_responder.sv
// Responder end of the sdc_* bus: serves single-word reads/writes from an on-chip array
// with fixed wait states and periodic refresh stalls that mimic SDRAM timing.
module sdc_mem_responder #(
  parameter int ADDR_BITS        = 10,
  parameter int READ_LATENCY     = 4,
  parameter int WRITE_LATENCY    = 2,
  parameter int REFRESH_INTERVAL = 64,
  parameter int REFRESH_CYCLES   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sdc_addr,
  input  logic [31:0] sdc_data,
  input  logic        sdc_we,
  input  logic        sdc_start,
  output logic [31:0] sdc_q,
  output logic        sdc_done,
  output logic        refresh_active
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int RI_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [RI_W-1:0] RF_MAX   = RI_W'((REFRESH_INTERVAL > 0) ? REFRESH_INTERVAL - 1 : 0);
  localparam logic [15:0]     RD_LOAD  = 16'(READ_LATENCY - 1);
  localparam logic [15:0]     WR_LOAD  = 16'(WRITE_LATENCY - 1);
  localparam logic [15:0]     REF_LOAD = 16'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, REFRESH} state_t;

  state_t                state;
  logic                  start_prev;
  logic                  pending;
  logic [15:0]           lat_cnt;
  logic [15:0]           ref_cnt;
  logic [RI_W-1:0]       rf_cnt;
  logic                  req_we;
  logic [ADDR_BITS-1:0]  req_addr;
  logic [31:0]           req_data;
  logic [31:0]           mem [DEPTH] = '{default: 32'h0};

  logic req;
  logic due;
  logic commit;
  logic latch_req;
  logic unused_addr_hi;

  function automatic logic [15:0] load_lat(input logic we);
    return we ? WR_LOAD : RD_LOAD;
  endfunction

  assign req       = sdc_start & ~start_prev;
  assign due       = (REFRESH_INTERVAL != 0) && (rf_cnt == RF_MAX);
  assign commit    = (state == WAIT) && (lat_cnt == '0);
  // Only IDLE and REFRESH accept a new request; a second edge while one is pending is dropped.
  assign latch_req = req && !pending && ((state == IDLE) || (state == REFRESH));
  assign unused_addr_hi = ^sdc_addr[31:ADDR_BITS];

  always_ff @(posedge clk) begin
    if (latch_req) begin
      req_we   <= sdc_we;
      req_addr <= sdc_addr[ADDR_BITS-1:0];
      req_data <= sdc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && req_we) mem[req_addr] <= req_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      start_prev     <= 1'b0;
      pending        <= 1'b0;
      lat_cnt        <= '0;
      ref_cnt        <= '0;
      rf_cnt         <= '0;
      sdc_q          <= '0;
      sdc_done       <= 1'b0;
      refresh_active <= 1'b0;
    end else begin
      start_prev <= sdc_start;
      sdc_done   <= 1'b0;

      if ((state == IDLE) && due)  rf_cnt <= '0;
      else if (rf_cnt != RF_MAX)   rf_cnt <= rf_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (due) begin
            state          <= REFRESH;
            refresh_active <= 1'b1;
            ref_cnt        <= REF_LOAD;
            if (req) pending <= 1'b1;
          end else if (pending) begin
            state   <= WAIT;
            lat_cnt <= load_lat(req_we);
            pending <= 1'b0;
          end else if (req) begin
            state   <= WAIT;
            lat_cnt <= load_lat(sdc_we);
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state    <= DONE;
            sdc_done <= 1'b1;
            if (!req_we) sdc_q <= mem[req_addr];
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        REFRESH: begin
          // A queued request starts its wait directly at the edge that ends the window.
          if (ref_cnt == '0) begin
            refresh_active <= 1'b0;
            if (pending) begin
              state   <= WAIT;
              lat_cnt <= load_lat(req_we);
              pending <= 1'b0;
            end else if (req) begin
              state   <= WAIT;
              lat_cnt <= load_lat(sdc_we);
            end else begin
              state <= IDLE;
            end
          end else begin
            ref_cnt <= ref_cnt - 1'b1;
            if (req) pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_mem_responder.sv
// Bench for sdc_mem_responder: vector table, directed corner sequences and a random
// phase checked against a word-array model and observed refresh windows.
module tb_sdc_mem_responder;

  localparam int RL = 4;
  localparam int WL = 2;
  localparam int RI = 64;
  localparam int RC = 6;
  localparam int M_NORM  = 0;
  localparam int M_ABORT = 1;
  localparam int M_HOLD  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sdc_addr;
  logic [31:0] sdc_data;
  logic        sdc_we;
  logic        sdc_start;
  logic [31:0] sdc_q;
  logic        sdc_done;
  logic        refresh_active;

  always #5 clk = ~clk;

  sdc_mem_responder dut (
    .clk           (clk),
    .reset         (reset),
    .sdc_addr      (sdc_addr),
    .sdc_data      (sdc_data),
    .sdc_we        (sdc_we),
    .sdc_start     (sdc_start),
    .sdc_q         (sdc_q),
    .sdc_done      (sdc_done),
    .refresh_active(refresh_active)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_q;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [1024];
  logic [31:0] last_q;
  int          cyc;
  bit          ra_prev;
  int          run_len;
  int          last_start;
  bit          mon_en;
  vec_t        vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; samples at the falling edge and tracks refresh windows.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (refresh_active) begin
      if (!ra_prev) begin
        if (mon_en && last_start >= 0)
          check("refresh_gap", 32'((cyc - last_start >= RI) && (cyc - last_start <= RI + RL + 1)), 32'd1);
        last_start = cyc;
      end
      run_len++;
    end else if (ra_prev) begin
      if (mon_en) check("refresh_len", 32'(run_len), 32'(RC));
      run_len = 0;
    end
    ra_prev = refresh_active;
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    sdc_start = 1'b0;
    reset     = 1'b0;
    tick();
    check("rst_q", sdc_q, 32'h0);
    check("rst_done", 32'(sdc_done), 32'd0);
    check("rst_refresh", 32'(refresh_active), 32'd0);
    tick();
    reset      = 1'b1;
    ra_prev    = 1'b0;
    run_len    = 0;
    last_start = -1;
    last_q     = 32'h0;
  endtask

  // Latency rule: done arrives LAT samples after capture plus every refresh sample seen meanwhile.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] data, input int mode);
    int idx;
    int nref;
    int extra;
    idx  = -1;
    nref = 0;
    sdc_we    = we;
    sdc_addr  = addr;
    sdc_data  = data;
    sdc_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mode == M_ABORT) sdc_start = 1'b0;
      if (sdc_done) begin
        idx = i;
        break;
      end
      if (refresh_active) nref++;
    end
    check(we ? "wr_latency" : "rd_latency", 32'(idx), 32'((we ? WL : RL) + nref));
    if (idx >= 0) begin
      if (we) model[addr[9:0]] = data;
      else    last_q = model[addr[9:0]];
      check(we ? "q_hold" : "rd_data", sdc_q, last_q);
    end
    if (mode == M_HOLD) begin
      extra = 0;
      repeat (20) begin
        tick();
        if (sdc_done) extra++;
      end
      check("held_start_extra_done", 32'(extra), 32'd0);
    end
    sdc_start = 1'b0;
    tick();
    check("done_pulse_width", 32'(sdc_done), 32'd0);
  endtask

  initial begin
    int ra_cnt;
    int done_idx;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0,          32'h0};
    vecs[1] = '{1'b1, 32'h0000_0005, 32'hDEADBEEF,   32'h0};
    vecs[2] = '{1'b0, 32'h0000_0005, 32'h0,          32'hDEADBEEF};
    vecs[3] = '{1'b1, 32'h0000_0405, 32'h12345678,   32'hDEADBEEF};
    vecs[4] = '{1'b0, 32'h0000_0005, 32'h0,          32'h12345678};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hA5A55A5A,   32'h12345678};
    vecs[6] = '{1'b0, 32'h0000_03FF, 32'h0,          32'hA5A55A5A};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'h0,          32'h0};
    vecs[8] = '{1'b1, 32'h0000_0000, 32'h0BADF00D,   32'h0};
    vecs[9] = '{1'b0, 32'h8000_0400, 32'h0,          32'h0BADF00D};
    cyc = 0; sdc_addr = '0; sdc_data = '0; sdc_we = 1'b0; ra_prev = 1'b0;
    run_len = 0; last_start = -1;

    do_reset();
    tick();
    check("post_rst_q", sdc_q, 32'h0);
    check("post_rst_done", 32'(sdc_done), 32'd0);

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].data, M_NORM);
      check("vec_q", sdc_q, vecs[i].exp_q);
    end

    xfer(1'b0, 32'h5, 32'h0, M_HOLD);
    check("held_q", sdc_q, 32'h12345678);

    xfer(1'b1, 32'h20, 32'hCAFEF00D, M_ABORT);
    xfer(1'b0, 32'h20, 32'h0, M_NORM);
    check("abort_written", sdc_q, 32'hCAFEF00D);

    xfer(1'b1, 32'h10, 32'h11111111, M_NORM);
    sdc_we = 1'b1; sdc_addr = 32'h10; sdc_data = 32'h22222222; sdc_start = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_done", 32'(sdc_done), 32'd0);
    check("midrst_q", sdc_q, 32'h0);
    check("midrst_refresh", 32'(refresh_active), 32'd0);
    repeat (3) begin
      tick();
      check("midrst_no_done", 32'(sdc_done), 32'd0);
    end
    sdc_start = 1'b0;
    reset = 1'b1; ra_prev = 1'b0; run_len = 0; last_q = 32'h0;
    tick();
    xfer(1'b0, 32'h10, 32'h0, M_NORM);
    check("midrst_word_kept", sdc_q, 32'h11111111);

    // Refresh collision: rising start sampled on the edge where the first refresh is taken.
    do_reset();
    repeat (RI - 1) tick();
    check("pre_refresh_idle", 32'(refresh_active), 32'd0);
    sdc_we = 1'b0; sdc_addr = 32'h5; sdc_start = 1'b1;
    ra_cnt = 0; done_idx = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (refresh_active) ra_cnt++;
      if (sdc_done) begin
        done_idx = i;
        break;
      end
    end
    check("collision_refresh_len", 32'(ra_cnt), 32'(RC));
    check("collision_done_idx", 32'(done_idx), 32'(RC + RL));
    check("collision_q", sdc_q, model[5]);
    last_q = model[5];
    sdc_start = 1'b0;
    tick();

    mon_en = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15));
      xfer(1'($urandom_range(0, 1)), a, $urandom(), ($urandom_range(0, 9) == 0) ? M_ABORT : M_NORM);
      repeat ($urandom_range(0, 3)) tick();
    end
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
